// File: rtl/tx_aux_sequencer.sv
// tx_aux_sequencer: emits aux/segment headers to a frame builder, then TERM_REPEAT end markers
module tx_aux_sequencer #(
    parameter logic [15:0] MAXAUX      = 16'h0fff,
    parameter int          MAXAUX_BITS = 12,
    parameter int          TERM_REPEAT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [15:0]            segment_number_max,
    input  logic [15:0]            gap_cycles,
    input  logic                   ready,
    output logic                   valid,
    output logic [MAXAUX_BITS:0]   aux,
    output logic [15:0]            segment_number,
    output logic [15:0]            sent_count,
    output logic                   busy,
    output logic                   done
);
    typedef enum logic [2:0] {IDLE, SEND, GAP, TERM, TERM_GAP, DONE} state_t;

    localparam logic [MAXAUX_BITS-1:0] LAST_AUX  = MAXAUX[MAXAUX_BITS-1:0];
    localparam logic [MAXAUX_BITS:0]   MARKER    = {1'b1, {MAXAUX_BITS{1'b0}}};
    localparam logic [15:0]            TERM_LAST = 16'(TERM_REPEAT - 1);

    state_t                 state_q, state_d;
    logic [MAXAUX_BITS:0]   aux_q;
    logic [15:0]            seg_q, seg_max_q, gap_q, gap_cnt_q, term_cnt_q, sent_q;
    logic                   xfer, accept, last_seg, last_data, last_term, gap_zero, gap_end;

    assign xfer      = valid && ready;
    assign accept    = start && (state_q == IDLE || state_q == DONE);
    assign last_seg  = seg_q == seg_max_q - 16'd1;
    assign last_data = last_seg && aux_q[MAXAUX_BITS-1:0] == LAST_AUX;
    assign last_term = term_cnt_q == TERM_LAST;
    assign gap_zero  = gap_q == 16'd0;
    assign gap_end   = gap_cnt_q == 16'd1;

    assign aux            = aux_q;
    assign segment_number = seg_q;
    assign sent_count     = sent_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: gaps are skipped entirely when the latched gap is zero
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = start ? SEND : state_q;
            SEND:       if (xfer) state_d = last_data ? (gap_zero ? TERM : TERM_GAP) : (gap_zero ? SEND : GAP);
            GAP:        state_d = gap_end ? SEND : GAP;
            TERM:       if (xfer) state_d = last_term ? DONE : (gap_zero ? TERM : TERM_GAP);
            TERM_GAP:   state_d = gap_end ? TERM : TERM_GAP;
            default:    state_d = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        valid = state_q == SEND || state_q == TERM;
        busy  = !(state_q == IDLE || state_q == DONE);
        done  = state_q == DONE;
    end

    // Datapath: latch run config on start, advance indices and counters on each transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            aux_q      <= '0;
            seg_q      <= '0;
            seg_max_q  <= 16'd1;
            gap_q      <= '0;
            gap_cnt_q  <= '0;
            term_cnt_q <= '0;
            sent_q     <= '0;
        end else if (accept) begin
            aux_q      <= '0;
            seg_q      <= '0;
            seg_max_q  <= segment_number_max == 16'd0 ? 16'd1 : segment_number_max;
            gap_q      <= gap_cycles;
            gap_cnt_q  <= '0;
            term_cnt_q <= '0;
            sent_q     <= '0;
        end else begin
            if (xfer) begin
                sent_q    <= sent_q == 16'hFFFF ? sent_q : sent_q + 16'd1;
                gap_cnt_q <= gap_q;
            end else if (state_q == GAP || state_q == TERM_GAP) begin
                gap_cnt_q <= gap_cnt_q - 16'd1;
            end
            if (xfer && state_q == SEND) begin
                seg_q <= last_seg ? 16'd0 : seg_q + 16'd1;
                if (last_seg) aux_q <= last_data ? MARKER : aux_q + (MAXAUX_BITS+1)'(1);
            end
            if (xfer && state_q == TERM) term_cnt_q <= term_cnt_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_tx_aux_sequencer.sv
// tb_tx_aux_sequencer: directed checks of the aux sequencer with MAXAUX=3, 2-bit index, 4 markers
module tb_tx_aux_sequencer;
    logic        clk = 1'b0;
    logic        rst, start, ready;
    logic [15:0] segment_number_max, gap_cycles;
    logic        valid, busy, done;
    logic [2:0]  aux;
    logic [15:0] segment_number, sent_count;
    int          tests = 0;
    int          fails = 0;

    tx_aux_sequencer #(.MAXAUX(16'd3), .MAXAUX_BITS(2), .TERM_REPEAT(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .segment_number_max(segment_number_max), .gap_cycles(gap_cycles),
        .ready(ready), .valid(valid), .aux(aux), .segment_number(segment_number),
        .sent_count(sent_count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_aux(int i, int segs);
        return (i < 4 * segs) ? 32'(i / segs) : 32'd4;
    endfunction

    function automatic logic [31:0] exp_seg(int i, int segs);
        return (i < 4 * segs) ? 32'(i % segs) : 32'd0;
    endfunction

    task automatic chk_xfer(input string tag, input int i, input int segs);
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_aux"}, 32'(aux), exp_aux(i, segs));
        chk({tag, "_seg"}, 32'(segment_number), exp_seg(i, segs));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_aux"}, 32'(aux), 32'd0);
        chk({tag, "_seg"}, 32'(segment_number), 32'd0);
        chk({tag, "_cnt"}, 32'(sent_count), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ready = 1'b1;
        segment_number_max = 16'd2; gap_cycles = 16'd0;
        step; step;
        rst = 1'b0;
        chk_reset("reset");

        // back-to-back run, seg_max=2, gap=0
        start = 1'b1; step; start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_done0", 32'(done), 32'd0);
        for (int i = 0; i < 12; i++) begin
            chk_xfer("b2b", i, 2);
            step;
        end
        chk("b2b_done", 32'(done), 32'd1);
        chk("b2b_busy_end", 32'(busy), 32'd0);
        chk("b2b_valid_end", 32'(valid), 32'd0);
        chk("b2b_cnt", 32'(sent_count), 32'd12);

        // gap=3 run started from DONE
        gap_cycles = 16'd3;
        start = 1'b1; step; start = 1'b0;
        chk("gap_cnt_clr", 32'(sent_count), 32'd0);
        chk("gap_done_clr", 32'(done), 32'd0);
        for (int i = 0; i < 12; i++) begin
            chk_xfer("gap", i, 2);
            step;
            if (i < 11) begin
                for (int g = 0; g < 3; g++) begin
                    chk("gap_low", 32'(valid), 32'd0);
                    step;
                end
            end
        end
        chk("gap_done", 32'(done), 32'd1);
        chk("gap_cnt", 32'(sent_count), 32'd12);

        // backpressure at aux=1 seg=0, start while busy, mid-run input changes
        gap_cycles = 16'd0;
        start = 1'b1; step; start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk_xfer("bp", i, 2);
            step;
        end
        ready = 1'b0; start = 1'b1;
        segment_number_max = 16'd1; gap_cycles = 16'd5;
        for (int k = 0; k < 5; k++) begin
            chk_xfer("bp_hold", 2, 2);
            chk("bp_hold_cnt", 32'(sent_count), 32'd2);
            step;
            start = 1'b0;
        end
        ready = 1'b1;
        for (int i = 2; i < 12; i++) begin
            chk_xfer("bp", i, 2);
            step;
        end
        chk("bp_done", 32'(done), 32'd1);
        chk("bp_cnt", 32'(sent_count), 32'd12);

        // seg_max=0 behaves as 1
        segment_number_max = 16'd0; gap_cycles = 16'd0;
        start = 1'b1; step; start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_xfer("seg0", i, 1);
            step;
        end
        chk("seg0_done", 32'(done), 32'd1);
        chk("seg0_cnt", 32'(sent_count), 32'd8);

        // reset mid-run at aux=2, then reset beats start
        segment_number_max = 16'd2;
        start = 1'b1; step; start = 1'b0;
        for (int i = 0; i < 4; i++) step;
        chk_xfer("pre_rst", 4, 2);
        rst = 1'b1; step; rst = 1'b0;
        chk_reset("midrst");
        rst = 1'b1; start = 1'b1; step; rst = 1'b0; start = 1'b0;
        chk("rst_prio_busy", 32'(busy), 32'd0);
        chk("rst_prio_valid", 32'(valid), 32'd0);
        start = 1'b1; step; start = 1'b0;
        chk_xfer("restart", 0, 2);
        chk("restart_cnt", 32'(sent_count), 32'd0);
        step;
        chk_xfer("restart", 1, 2);
        chk("restart_cnt1", 32'(sent_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tx_aux_sequencer.md
TX_AUX_SEQUENCER -- requirements
Module: tx_aux_sequencer

Interface
REQ-001 Parameter MAXAUX, default 16'h0fff: last data sequence index sent.
REQ-002 Parameter MAXAUX_BITS, default 12: aux index width; aux port is MAXAUX_BITS+1 bits, MSB is the end marker.
REQ-003 Parameter TERM_REPEAT, default 4: number of end-marker transfers sent.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  one-cycle request to begin a run; ignored unless state is IDLE or DONE.
REQ-008 segment_number_max  in  16  segments per aux index; latched on accepted start.
REQ-009 gap_cycles  in  16  idle cycles after each accepted transfer; latched on accepted start.
REQ-010 ready  in  1  frame builder accepts the current header this cycle.
REQ-011 valid  out  1  header fields are valid.
REQ-012 aux  out  MAXAUX_BITS+1  sequence index, or end marker {1'b1, zeros}.
REQ-013 segment_number  out  16  segment within current aux index.
REQ-014 sent_count  out  16  accepted transfers this run, saturating at 16'hFFFF.
REQ-015 busy  out  1  high in all states except IDLE and DONE.
REQ-016 done  out  1  high in DONE only.

Function
REQ-017 States: IDLE, SEND, GAP, TERM, TERM_GAP, DONE.
REQ-018 Transfer occurs on a cycle with valid && ready; valid is high only in SEND and TERM.
REQ-019 While valid && !ready, aux and segment_number are held stable and valid stays high.
REQ-020 Accepted start in IDLE/DONE: latch inputs, aux=0, segment_number=0, sent_count=0, done=0, enter SEND next cycle.
REQ-021 Latched segment_number_max of 0 is treated as 1.
REQ-022 Data order: for each aux 0..MAXAUX ascending, segment_number 0..seg_max-1 ascending.
REQ-023 On a SEND transfer: if segment_number+1==seg_max, segment_number=0 and aux increments; otherwise segment_number increments.
REQ-024 A SEND transfer at aux==MAXAUX, last segment, loads aux={1'b1, zeros} and segment_number=0, then targets TERM.
REQ-025 After any transfer, latched gap==0 proceeds directly to the target state (valid can remain high back-to-back); otherwise enter GAP/TERM_GAP for exactly gap cycles with valid low.
REQ-026 TERM sends the end marker TERM_REPEAT times, separated by gaps per REQ-025; fields are constant across repeats.
REQ-027 After the TERM_REPEAT-th marker transfer, enter DONE: done=1, busy=0, valid=0; sent_count holds.
REQ-028 sent_count increments on every transfer (data and marker) and saturates at 16'hFFFF, with no wrap.
REQ-029 A start arriving while busy has no effect; a start in DONE begins a fresh run.
REQ-030 Input changes to segment_number_max or gap_cycles mid-run have no effect.

Reset
REQ-031 rst at any cycle, including mid-transfer: next cycle state=IDLE, valid=0, aux=0, segment_number=0, sent_count=0, busy=0, done=0; the in-flight header is abandoned.
REQ-032 rst has priority over start on the same cycle.

Verification
REQ-033 MAXAUX=3, MAXAUX_BITS=2, TERM_REPEAT=4, seg_max=2, gap=0, ready=1, start pulse -> aux/seg sequence 0/0,0/1,1/0,1/1,2/0,2/1,3/0,3/1, then 4x aux=3'b100 seg 0, in 12 consecutive valid cycles; then done=1 and sent_count=12.
REQ-034 Same as REQ-033 but gap=3 -> exactly 3 valid-low cycles between each transfer; 12 transfers total, done after the last.
REQ-035 ready low for 5 cycles while aux=1, seg=0 -> valid held and fields stable for 5 cycles, with no skipped or duplicated index.
REQ-036 seg_max=0 -> behaves as seg_max=1: aux 0..3 with seg 0 each, then 4 markers, sent_count=8.
REQ-037 rst asserted while aux=2 and valid high -> next cycle all outputs are at reset values; a following start restarts from aux=0.
REQ-038 start pulsed while busy at aux=1 -> sequence unaffected; start in DONE -> new run with sent_count cleared to 0.
